ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the datapath's instruction input. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake that tolerates variable latency. Returned words are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake. A PC redirect from a taken branch or jump flushes everything in flight.

Parameters:
width, 32, address/PC width; matches the datapath width parameter
DEPTH, 4, prefetch FIFO entries; power of two, at least 2
RESET_PC, 0, fetch PC loaded on reset; word aligned

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  width  word-aligned fetch address
imem_ack  in  1  one-cycle pulse: imem_rdata is valid this cycle
imem_rdata  in  32  fetched instruction word
redirect  in  1  one-cycle pulse: discard queue, restart fetch at redirect_pc
redirect_pc  in  width  new fetch PC; bits [1:0] are ignored and forced to 0
inst_valid  out  1  head of queue is valid
inst  out  32  head instruction word
inst_pc  out  width  PC of the head instruction
inst_ready  in  1  decode consumes the head this cycle

Behaviour:
- Reset (async assert; state cleared immediately): fetch_pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding, and its response will be discarded.
- IDLE→WAIT when count<DEPTH and no redirect. A request is only issued when a FIFO slot is free, so at most one request is outstanding.
- WAIT:
  - imem_req=1.
  - imem_addr=fetch_pc, held stable until ack.
  - On ack: push {imem_rdata, fetch_pc}, fetch_pc+=4, then go to WAIT again if space remains after the push, else IDLE. Back-to-back requests are allowed.
- DROP:
  - imem_req stays 1 with the old address until ack.
  - The ack's data is discarded.
  - Then go to IDLE, with fetch_pc already holding redirect_pc.
- Redirect, any state:
  - Flush the FIFO (count=0, pointers reset).
  - fetch_pc={redirect_pc[width-1:2],2'b00}.
  - WAIT→DROP; DROP stays DROP; IDLE stays IDLE, and issues from the new PC on the next cycle.
  - If ack and redirect occur in the same cycle, the ack is consumed: no push, and the state goes to IDLE (not DROP).
  - Redirect has priority over push and pop in the same cycle; inst_valid=0 on the next cycle.
- Output side: inst_valid=(count!=0); inst/inst_pc = head entry, registered storage. Pop when inst_valid&inst_ready.
- Same-cycle push and pop: count unchanged, both pointers advance.
- A push is never lost: issue is gated by free space, so a push into a full FIFO cannot occur.
- Latency (no bypass): ack in cycle N → inst_valid in cycle N+1.
- Throughput: one instruction per imem round trip.
- Wrap-around:
  - fetch_pc wraps modulo 2^width (0xFFFFFFFC+4 = 0x0).
  - FIFO pointers wrap modulo DEPTH.
- inst_ready while empty: ignored.

Optional Feature:
Macro IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, state=WAIT, imem_ack=1, inst_ready=1 and there is no redirect:
  - imem_rdata and fetch_pc are driven combinationally onto inst and inst_pc, with inst_valid=1 in the same cycle.
  - The word is not pushed.
  - With bypass, inst_valid/inst/inst_pc have a combinational path from imem_ack/imem_rdata.
- Not defined: all outputs are registered and the fixed one-cycle ack-to-valid latency applies.

Test Plan:
1. Reset, then imem acks every 2nd cycle, inst_ready=1 → decode sees PCs 0x0,0x4,0x8,0xC in order with the matching rdata; imem_req drops while waiting for an ack only if the FIFO is full.
2. inst_ready=0, DEPTH=4 → exactly 4 acks accepted, count=4, imem_req=0; raise inst_ready → 4 pops, then fetch resumes at 0x10.
3. Redirect to 0x103 while a request for 0x8 is outstanding → FIFO flushed, next-cycle inst_valid=0, the ack for 0x8 is discarded, the next imem_addr is 0x100, and the first inst_pc is 0x100.
4. Redirect and imem_ack in the same cycle → no push, state IDLE, next request at redirect_pc, and the acked word never appears.
5. RESET_PC=0xFFFFFFF8, 3 fetches → inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
6. Assert rst mid-WAIT with 2 entries queued → outputs reset immediately (async), with no stale pop after release; with IFQ_BYPASS_EN defined and the FIFO empty, ack and inst_ready in cycle N give inst_valid=1 in cycle N.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single outstanding imem requests,
// buffers returned words in a prefetch FIFO. Optional macro IFQ_BYPASS_EN adds an empty-FIFO bypass.
module ifetch_queue #(
  parameter int unsigned       width    = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [width-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [width-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [width-1:0] redirect_pc,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [width-1:0] inst_pc,
  input  logic             inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]    CONE  = CW'(1);
  localparam logic [AW-1:0]    PONE  = AW'(1);
  localparam logic [width-1:0] STEP  = width'(4);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] fetch_pc_q, fetch_pc_d;
  logic [width-1:0] drop_addr_q;
  logic [31:0]      data_q [DEPTH];
  logic [width-1:0] pc_q   [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_n;
  logic             push, pop, bypass;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

`ifdef IFQ_BYPASS_EN
  assign bypass = (count_q == '0) && (state_q == WAIT) && imem_ack && inst_ready && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign push = (state_q == WAIT) && imem_ack && !redirect && !bypass;
  assign pop  = (count_q != '0) && inst_ready && !redirect;

  always_comb begin
    count_n = count_q;
    if (push && !pop)
      count_n = count_q + CONE;
    else if (pop && !push)
      count_n = count_q - CONE;
  end

  // A new request is only issued while a slot is free, so a push can never hit a full FIFO.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: if (!redirect && (count_q < FULL)) state_d = WAIT;
      WAIT: begin
        if (redirect)
          state_d = imem_ack ? IDLE : DROP;
        else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + STEP;
          state_d    = (count_n < FULL) ? WAIT : IDLE;
        end
      end
      DROP: if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect)
      fetch_pc_d = {redirect_pc[width-1:2], 2'b00};
  end

  // drop_addr_q shadows the outstanding address so DROP keeps presenting it after fetch_pc moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (state_q == WAIT)
        drop_addr_q <= fetch_pc_q;
      if (push) begin
        data_q[wr_ptr_q] <= imem_rdata;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PONE;
        count_q <= count_n;
      end
    end
  end

  always_comb begin
    imem_req   = (state_q != IDLE);
    imem_addr  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    inst_valid = (count_q != '0);
    inst       = data_q[rd_ptr_q];
    inst_pc    = pc_q[rd_ptr_q];
    if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed scoreboard bench for ifetch_queue; expectations adapt when IFQ_BYPASS_EN is defined.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic        req2, ack2, valid2, ready2;
  logic [31:0] addr2, rdata2, inst2, pc2;

  entry_t      sb[$];
  entry_t      sb2[$];
  entry_t      e;
  logic [31:0] exp_pc, exp2;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.width(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  ifetch_queue #(.width(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .redirect(1'b0),
    .redirect_pc(32'h0000_0000), .inst_valid(valid2), .inst(inst2),
    .inst_pc(pc2), .inst_ready(ready2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  // One cycle: check any consumption at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (inst_valid && inst_ready) begin
      chk("pop_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_inst", inst, e.data);
        chk("pop_pc", inst_pc, e.pc);
      end
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
    ack2     = 1'b0;
  endtask

  task automatic do_ack();
    chk("ack_req", 32'(imem_req), 32'd1);
    chk("ack_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = word(exp_pc);
    sb.push_back('{data: word(exp_pc), pc: exp_pc});
    exp_pc = exp_pc + 32'd4;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; inst_ready = 0;
    ack2 = 0; rdata2 = 0; ready2 = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);
    rst = 1'b0;
    exp_pc = 32'h0;
    inst_ready = 1'b1;
    tick();

    // ack every second cycle, decode always ready
    for (int i = 0; i < 4; i++) begin
      chk("t1_req_held", 32'(imem_req), 32'd1);
      tick();
      chk("t1_addr", imem_addr, exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = word(exp_pc);
      sb.push_back('{data: word(exp_pc), pc: exp_pc});
      exp_pc = exp_pc + 32'd4;
      #1;
      chk("t1_latency", 32'(inst_valid), 32'(BYP));
      tick();
    end
    tick();
    chk("t1_drained", 32'(sb.size()), 32'd0);

    // fill to DEPTH with decode stalled, then drain
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_ack();
    chk("t2_full_req", 32'(imem_req), 32'd0);
    chk("t2_full_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h10);
    tick();
    chk("t2_full_req2", 32'(imem_req), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_drained", 32'(sb.size()), 32'd0);
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h20);

    // redirect with a request outstanding and two entries queued
    inst_ready = 1'b0;
    do_ack();
    do_ack();
    chk("t3_pre_valid", 32'(inst_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    sb.delete();
    tick();
    chk("t3_flush_valid", 32'(inst_valid), 32'd0);
    chk("t3_drop_req", 32'(imem_req), 32'd1);
    chk("t3_drop_addr", imem_addr, 32'h28);
    inst_ready = 1'b1;
    tick();
    chk("t3_drop_addr2", imem_addr, 32'h28);
    imem_ack = 1'b1;
    imem_rdata = word(32'h28);
    tick();
    chk("t3_idle_req", 32'(imem_req), 32'd0);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_no_stale", 32'(inst_valid), 32'd0);
    exp_pc = 32'h100;
    tick();
    do_ack();
    tick();
    chk("t3_drained", 32'(sb.size()), 32'd0);

    // redirect and ack in the same cycle
    chk("t4_addr", imem_addr, 32'h104);
    imem_ack = 1'b1;
    imem_rdata = word(32'h104);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("t4_idle_req", 32'(imem_req), 32'd0);
    chk("t4_addr_new", imem_addr, 32'h200);
    chk("t4_no_push", 32'(inst_valid), 32'd0);
    exp_pc = 32'h200;
    tick();
    do_ack();
    tick();
    chk("t4_drained", 32'(sb.size()), 32'd0);

    // async reset mid-WAIT with two entries queued
    inst_ready = 1'b0;
    do_ack();
    do_ack();
    chk("t6_pre_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_req", 32'(imem_req), 32'd0);
    chk("t6_async_addr", imem_addr, 32'h0);
    chk("t6_async_valid", 32'(inst_valid), 32'd0);
    chk("t6_async_inst", inst, 32'h0);
    chk("t6_async_pc", inst_pc, 32'h0);
    sb.delete();
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 32'h0;
    chk("t6_post_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("t6_post_valid2", 32'(inst_valid), 32'd0);
    chk("t6_restart_req", 32'(imem_req), 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0);

    // fetch PC wrap on the second instance
    exp2 = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      chk("t5_req", 32'(req2), 32'd1);
      chk("t5_addr", addr2, exp2);
      ack2   = 1'b1;
      rdata2 = word(exp2);
      sb2.push_back('{data: word(exp2), pc: exp2});
      exp2 = exp2 + 32'd4;
`ifdef IFQ_BYPASS_EN
      #1;
      e = sb2.pop_front();
      chk("t5_byp_valid", 32'(valid2), 32'd1);
      chk("t5_byp_pc", pc2, e.pc);
      chk("t5_byp_inst", inst2, e.data);
      tick();
`else
      tick();
      e = sb2.pop_front();
      chk("t5_valid", 32'(valid2), 32'd1);
      chk("t5_pc", pc2, e.pc);
      chk("t5_inst", inst2, e.data);
`endif
    end
    chk("t5_wrapped_addr", addr2, 32'h4);
    tick();
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
